// File: rtl/tmc_spi_sequencer.sv
// Command sequencer for the 40-bit TMC SPI master: request -> datagram -> timed send window -> response.
// Optional build macro TMC_READ_DOUBLE_EN: reads run two frames and return the second frame's word.
module tmc_spi_sequencer #(
  parameter int CS_SIZE      = 1,
  parameter int CNT_SIZE     = 16,
  parameter int FRAME_CYCLES = 1024,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                req_valid_in,
  output logic                req_ready_out,
  input  logic                req_write_in,
  input  logic [6:0]          req_addr_in,
  input  logic [31:0]         req_data_in,
  input  logic [CS_SIZE-1:0]  req_cs_in,
  output logic                resp_valid_out,
  output logic [7:0]          resp_status_out,
  output logic [31:0]         resp_data_out,
  output logic                busy_out,
  output logic [39:0]         spi_data_out,
  output logic [CS_SIZE-1:0]  spi_cs_select_out,
  output logic                spi_send_enable_out,
  input  logic [39:0]         spi_data_in
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, CAPTURE, GAP} state_e;

  localparam logic [CNT_SIZE-1:0] FRAME_LAST = CNT_SIZE'(FRAME_CYCLES - 1);
  localparam logic [CNT_SIZE-1:0] GAP_LAST   = CNT_SIZE'(GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_SIZE-1:0]  cnt_q, cnt_d;
  logic                 dbl_q, dbl_d;
  logic                 se_q, se_d;
  logic [39:0]          data_q, data_d;
  logic [CS_SIZE-1:0]   cs_q, cs_d;
  logic                 rv_q, rv_d;
  logic [7:0]           status_q, status_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dbl_d    = dbl_q;
    data_d   = data_q;
    cs_d     = cs_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    rv_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_in && ready_q) begin
          data_d  = {req_write_in, req_addr_in, req_data_in};
          cs_d    = req_cs_in;
`ifdef TMC_READ_DOUBLE_EN
          dbl_d   = ~req_write_in;
`else
          dbl_d   = 1'b0;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (cnt_q == FRAME_LAST) state_d = CAPTURE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      CAPTURE: begin
        cnt_d   = '0;
        state_d = GAP;
        // A pending second frame means this word answers the previous datagram; drop it.
        if (!dbl_q) begin
          status_d = spi_data_in[39:32];
          rdata_d  = spi_data_in[31:0];
          rv_d     = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (dbl_q) begin
            dbl_d   = 1'b0;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    se_d    = (state_d == SEND);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dbl_q    <= 1'b0;
      se_q     <= 1'b0;
      data_q   <= '0;
      cs_q     <= '0;
      rv_q     <= 1'b0;
      status_q <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dbl_q    <= dbl_d;
      se_q     <= se_d;
      data_q   <= data_d;
      cs_q     <= cs_d;
      rv_q     <= rv_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign req_ready_out       = ready_q;
  assign busy_out            = busy_q;
  assign spi_data_out        = data_q;
  assign spi_cs_select_out   = cs_q;
  assign spi_send_enable_out = se_q;
  assign resp_valid_out      = rv_q;
  assign resp_status_out     = status_q;
  assign resp_data_out       = rdata_q;

endmodule

// File: tb/tb_tmc_spi_sequencer.sv
// Bench for tmc_spi_sequencer: per-cycle timeline model derived from frame/gap lengths, random requests.
module tb_tmc_spi_sequencer;
  localparam int FR = 8;
  localparam int GP = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic        req_write_in = 1'b0;
  logic [6:0]  req_addr_in = '0;
  logic [31:0] req_data_in = '0;
  logic [0:0]  req_cs_in = '0;
  logic        resp_valid_out;
  logic [7:0]  resp_status_out;
  logic [31:0] resp_data_out;
  logic        busy_out;
  logic [39:0] spi_data_out;
  logic [0:0]  spi_cs_select_out;
  logic        spi_send_enable_out;
  logic [39:0] spi_data_in = '0;

  int tests = 0;
  int fails = 0;

  tmc_spi_sequencer #(.CS_SIZE(1), .CNT_SIZE(16), .FRAME_CYCLES(FR), .GAP_CYCLES(GP)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_write_in(req_write_in), .req_addr_in(req_addr_in),
    .req_data_in(req_data_in), .req_cs_in(req_cs_in),
    .resp_valid_out(resp_valid_out), .resp_status_out(resp_status_out),
    .resp_data_out(resp_data_out), .busy_out(busy_out),
    .spi_data_out(spi_data_out), .spi_cs_select_out(spi_cs_select_out),
    .spi_send_enable_out(spi_send_enable_out), .spi_data_in(spi_data_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Waits (bounded) for ready, presents a request, and returns #1 after the accepting edge.
  task automatic do_accept(input bit w, input logic [6:0] a, input logic [31:0] d, input logic [0:0] cs);
    int i;
    i = 0;
    while (req_ready_out !== 1'b1 && i < 50) begin
      step();
      i++;
    end
    tests++;
    if (req_ready_out !== 1'b1) begin
      fails++;
      $display("FAIL accept_wait: ready=%b required 1", req_ready_out);
    end
    req_valid_in = 1'b1; req_write_in = w; req_addr_in = a; req_data_in = d; req_cs_in = cs;
    step();
    req_valid_in = 1'b0;
  endtask

  // Timeline after accept edge 0: enable on edges 1..FR, resp pulse after edge FR+2, ready after FR+GP+2.
  task automatic check_frame(input logic [39:0] dg, input logic [0:0] cs, input logic [39:0] rsp,
                             input bit inject, input logic [39:0] dg2);
    spi_data_in = rsp;
    for (int k = 0; k <= FR + GP + 2; k++) begin
      if (k > 0) step();
      tests++;
      if (spi_send_enable_out !== (k >= 1 && k <= FR)) begin
        fails++;
        $display("FAIL send_enable k=%0d: got %b required %b", k, spi_send_enable_out, (k >= 1 && k <= FR));
      end
      tests++;
      if (resp_valid_out !== (k == FR + 2)) begin
        fails++;
        $display("FAIL resp_valid k=%0d: got %b required %b", k, resp_valid_out, (k == FR + 2));
      end
      tests++;
      if (req_ready_out !== (k >= FR + GP + 2) || busy_out !== (k < FR + GP + 2)) begin
        fails++;
        $display("FAIL ready_busy k=%0d: got %b/%b", k, req_ready_out, busy_out);
      end
      tests++;
      if (spi_data_out !== dg || spi_cs_select_out !== cs) begin
        fails++;
        $display("FAIL datagram k=%0d: got %h/%b required %h/%b", k, spi_data_out, spi_cs_select_out, dg, cs);
      end
      if (k >= FR + 2) begin
        tests++;
        if ({resp_status_out, resp_data_out} !== rsp) begin
          fails++;
          $display("FAIL resp_word k=%0d: got %h required %h", k, {resp_status_out, resp_data_out}, rsp);
        end
      end
      if (inject && k == 3) begin
        req_valid_in = 1'b1; req_write_in = dg2[39]; req_addr_in = dg2[38:32]; req_data_in = dg2[31:0];
        req_cs_in = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (spi_send_enable_out !== 0 || spi_data_out !== 0 || spi_cs_select_out !== 0 || resp_valid_out !== 0 ||
        resp_status_out !== 0 || resp_data_out !== 0 || busy_out !== 0) begin
      fails++;
      $display("FAIL reset_outputs: se=%b data=%h rv=%b st=%h rd=%h busy=%b", spi_send_enable_out,
               spi_data_out, resp_valid_out, resp_status_out, resp_data_out, busy_out);
    end
    step();
    rst_in = 1'b0;
    step();
    tests++;
    if (req_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%b busy=%b required 1/0", req_ready_out, busy_out);
    end
  endtask

  task automatic test_write();
    do_accept(1'b1, 7'h6C, 32'h000100C3, 1'b0);
    tests++;
    if (spi_data_out !== 40'hEC000100C3) begin
      fails++;
      $display("FAIL write_datagram: got %h required ec000100c3", spi_data_out);
    end
    check_frame(40'hEC000100C3, 1'b0, 40'h05_12345678, 1'b0, '0);
  endtask

  task automatic test_read();
    do_accept(1'b0, 7'h6F, 32'h0, 1'b1);
    check_frame({1'b0, 7'h6F, 32'h0}, 1'b1, 40'h1A_DEADBEEF, 1'b0, '0);
    step();
    tests++;
    if (resp_valid_out !== 1'b0 || resp_status_out !== 8'h1A || resp_data_out !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL read_hold: rv=%b st=%h d=%h", resp_valid_out, resp_status_out, resp_data_out);
    end
  endtask

  task automatic test_busy_ignore();
    logic [39:0] a, b;
    a = {1'b1, 7'h22, 32'hA5A5_0001};
    b = {1'b0, 7'h33, 32'h0000_BEEF};
    do_accept(a[39], a[38:32], a[31:0], 1'b0);
    check_frame(a, 1'b0, 40'h77_00000001, 1'b1, b);
    step();
    req_valid_in = 1'b0;
    tests++;
    if (spi_data_out !== b || req_ready_out !== 1'b0 || spi_cs_select_out !== 1'b1) begin
      fails++;
      $display("FAIL busy_accept: got %h ready=%b required %h ready=0", spi_data_out, req_ready_out, b);
    end
    check_frame(b, 1'b1, 40'h88_00000002, 1'b0, '0);
  endtask

  task automatic test_reset_midframe();
    do_accept(1'b1, 7'h10, 32'hCAFE_F00D, 1'b0);
    for (int k = 1; k <= 4; k++) step();
    tests++;
    if (spi_send_enable_out !== 1'b1) begin
      fails++;
      $display("FAIL midframe_pre: se=%b required 1", spi_send_enable_out);
    end
    rst_in = 1'b1;
    #1;
    tests++;
    if (spi_send_enable_out !== 1'b0 || busy_out !== 1'b0 || spi_data_out !== 40'h0) begin
      fails++;
      $display("FAIL midframe_abort: se=%b busy=%b data=%h required 0/0/0", spi_send_enable_out, busy_out,
               spi_data_out);
    end
    step();
    rst_in = 1'b0;
    for (int k = 0; k < FR + GP + 4; k++) begin
      step();
      tests++;
      if (resp_valid_out !== 1'b0 || spi_send_enable_out !== 1'b0) begin
        fails++;
        $display("FAIL midframe_quiet k=%0d: rv=%b se=%b required 0/0", k, resp_valid_out, spi_send_enable_out);
      end
    end
    do_accept(1'b0, 7'h01, 32'h0, 1'b0);
    check_frame({1'b0, 7'h01, 32'h0}, 1'b0, 40'h3C_0BADCAFE, 1'b0, '0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [39:0] dg, rsp;
      logic [0:0]  cs;
      dg  = {$urandom_range(0, 1) == 1, 7'($urandom), 32'($urandom)};
      rsp = {8'($urandom), 32'($urandom)};
      cs  = 1'($urandom);
      do_accept(dg[39], dg[38:32], dg[31:0], cs);
      check_frame(dg, cs, rsp, 1'b0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy_ignore();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
